// File: rtl/wenneb_uart_pkg.sv
// Shared types and line levels for the wenneb UART transmitter.
// The optional parity feature is enabled by defining WENNEB_UART_PARITY_EN.
package wenneb_uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_t;

  localparam logic UART_IDLE_LEVEL  = 1'b1;
  localparam logic UART_START_LEVEL = 1'b0;

  // Even parity: the parity bit makes the count of ones in data+parity even.
  function automatic logic even_parity(input logic [7:0] data);
    return ^data;
  endfunction

endpackage

// File: rtl/wenneb_uart_if.sv
// Byte-in / serial-out port bundle between on-chip logic and the UART transmitter.
interface wenneb_uart_if;

  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       tx_line;
  logic       tx_oe;
  logic       tx_busy;

  modport master (
    output tx_data, tx_valid,
    input  tx_ready, tx_line, tx_oe, tx_busy
  );

  modport slave (
    input  tx_data, tx_valid,
    output tx_ready, tx_line, tx_oe, tx_busy
  );

endinterface

// File: rtl/wenneb_baud_gen.sv
// Bit-period timer: bit_done marks the last clk of every CLKS_PER_BIT-cycle bit.
// Held at zero while clr is high, so the first bit after a handshake is full length.
module wenneb_baud_gen #(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic bit_done
);

  localparam int                CNT_W    = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] cnt_q;

  // Wrapping to zero on the terminal count keeps every bit exactly N cycles.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt_q <= '0;
    end else if (cnt_q == CNT_LAST) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign bit_done = !clr && (cnt_q == CNT_LAST);

endmodule

// File: rtl/wenneb_uart_tx.sv
// Byte-wide UART transmitter, 8N1 by default, 8E1 when WENNEB_UART_PARITY_EN is defined.
// All outputs are registered; tx_line maps to uio_out[0], tx_oe to uio_oe[0].
module wenneb_uart_tx
  import wenneb_uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434,
  parameter int DATA_BITS    = 8
) (
  input  logic         clk,
  input  logic         rst,
  wenneb_uart_if.slave bus
);

  if (CLKS_PER_BIT < 2 || CLKS_PER_BIT > 65535 || DATA_BITS != 8) begin : g_bad_cfg
    $error("wenneb_uart_tx: CLKS_PER_BIT must be 2..65535 and DATA_BITS must be 8");
  end

  localparam logic [2:0] LAST_BIT = 3'(DATA_BITS - 1);

  tx_state_t            state_q, state_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [2:0]           bit_cnt_q, bit_cnt_d;
  logic                 line_q, line_d;
  logic                 ready_q, ready_d;
  logic                 busy_q, busy_d;
  logic                 oe_q;
  logic                 bit_done;
`ifdef WENNEB_UART_PARITY_EN
  logic                 parity_q, parity_d;
`endif

  wenneb_baud_gen #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud_gen (
    .clk     (clk),
    .rst     (rst),
    .clr     (state_q == IDLE),
    .bit_done(bit_done)
  );

  // NOTE: sequential state uses non-blocking <= so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      shift_q   <= '0;
      bit_cnt_q <= '0;
      line_q    <= UART_IDLE_LEVEL;
      ready_q   <= 1'b1;
      busy_q    <= 1'b0;
      oe_q      <= 1'b1;
`ifdef WENNEB_UART_PARITY_EN
      parity_q  <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      bit_cnt_q <= bit_cnt_d;
      line_q    <= line_d;
      ready_q   <= ready_d;
      busy_q    <= busy_d;
      oe_q      <= 1'b1;
`ifdef WENNEB_UART_PARITY_EN
      parity_q  <= parity_d;
`endif
    end
  end

  always_comb begin
    // NOTE: every variable gets its hold value first so no latch can be inferred.
    state_d   = state_q;
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    line_d    = line_q;
    ready_d   = ready_q;
    busy_d    = busy_q;
`ifdef WENNEB_UART_PARITY_EN
    parity_d  = parity_q;
`endif

    case (state_q)
      IDLE: begin
        line_d  = UART_IDLE_LEVEL;
        ready_d = 1'b1;
        busy_d  = 1'b0;
        // The start bit is driven on the handshake edge itself.
        if (bus.tx_valid && ready_q) begin
          state_d   = START;
          shift_d   = bus.tx_data;
          bit_cnt_d = '0;
          line_d    = UART_START_LEVEL;
          ready_d   = 1'b0;
          busy_d    = 1'b1;
`ifdef WENNEB_UART_PARITY_EN
          parity_d  = even_parity(bus.tx_data);
`endif
        end
      end

      START: begin
        if (bit_done) begin
          state_d = DATA;
          line_d  = shift_q[0];
        end
      end

      DATA: begin
        if (bit_done) begin
          if (bit_cnt_q == LAST_BIT) begin
`ifdef WENNEB_UART_PARITY_EN
            state_d = PARITY;
            line_d  = parity_q;
`else
            state_d = STOP;
            line_d  = UART_IDLE_LEVEL;
`endif
          end else begin
            bit_cnt_d = bit_cnt_q + 3'd1;
            shift_d   = shift_q >> 1;
            line_d    = shift_q[1];
          end
        end
      end

`ifdef WENNEB_UART_PARITY_EN
      PARITY: begin
        if (bit_done) begin
          state_d = STOP;
          line_d  = UART_IDLE_LEVEL;
        end
      end
`endif

      STOP: begin
        if (bit_done) begin
          state_d = IDLE;
          line_d  = UART_IDLE_LEVEL;
          ready_d = 1'b1;
          busy_d  = 1'b0;
        end
      end

      default: begin
        state_d = IDLE;
        line_d  = UART_IDLE_LEVEL;
        ready_d = 1'b1;
        busy_d  = 1'b0;
      end
    endcase
  end

  assign bus.tx_line  = line_q;
  assign bus.tx_ready = ready_q;
  assign bus.tx_busy  = busy_q;
  assign bus.tx_oe    = oe_q;

endmodule

// File: tb/tb_wenneb_uart_tx.sv
// Directed bench for wenneb_uart_tx with CLKS_PER_BIT=4; bytes are queued at handshake
// and the serial line is checked bit-by-bit, cycle-by-cycle against the popped byte.
module tb_wenneb_uart_tx;

  localparam int N = 4;
`ifdef WENNEB_UART_PARITY_EN
  localparam int FRAME_BITS = 11;
`else
  localparam int FRAME_BITS = 10;
`endif

  logic        clk = 1'b0;
  logic        rst;
  int unsigned cyc = 0;
  int          errors = 0;
  int          checks = 0;
  logic [7:0]  exp_q[$];
  int unsigned hs_cyc;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  wenneb_uart_if bus ();

  wenneb_uart_tx #(
    .CLKS_PER_BIT(N),
    .DATA_BITS   (8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic wait_ready();
    int n = 0;
    while (bus.tx_ready !== 1'b1 && n < 20 * N) begin
      tick();
      n++;
    end
    check("ready_wait", bus.tx_ready, 1);
  endtask

  // Drives one handshake; returns at #1 after the handshake edge.
  task automatic send(input logic [7:0] d, input bit hold);
    wait_ready();
    bus.tx_data  = d;
    bus.tx_valid = 1'b1;
    exp_q.push_back(d);
    tick();
    hs_cyc = cyc;
    if (!hold) bus.tx_valid = 1'b0;
  endtask

  // Called at #1 after the handshake edge; walks the whole frame one cycle at a time.
  // poke >= 0 pulses tx_valid with 0x3C at that cycle index of the frame.
  task automatic check_frame(input int poke);
    logic [7:0]            b;
    logic [FRAME_BITS-1:0] bits;
    int                    idx;
    check("sb_has_byte", exp_q.size() > 0, 1);
    if (exp_q.size() == 0) return;
    b = exp_q.pop_front();
`ifdef WENNEB_UART_PARITY_EN
    bits = {1'b1, ^b, b, 1'b0};
`else
    bits = {1'b1, b, 1'b0};
`endif
    check($sformatf("busy_start_%02h", b), bus.tx_busy, 1);
    for (int k = 0; k < FRAME_BITS; k++) begin
      for (int j = 0; j < N; j++) begin
        idx = k * N + j;
        if (poke >= 0 && idx == poke) begin
          bus.tx_data  = 8'h3C;
          bus.tx_valid = 1'b1;
        end else if (poke >= 0 && idx == poke + 1) begin
          bus.tx_valid = 1'b0;
        end
        check($sformatf("line_%02h_bit%0d_c%0d", b, k, j), bus.tx_line, bits[k]);
        if (k == FRAME_BITS - 1 && j == N - 1)
          check($sformatf("ready_low_last_%02h", b), bus.tx_ready, 0);
        tick();
      end
    end
    check($sformatf("ready_after_%02h", b), bus.tx_ready, 1);
    check($sformatf("busy_after_%02h", b), bus.tx_busy, 0);
  endtask

  initial begin
    #(200000 * 10);
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned first_hs;

    rst          = 1'b1;
    bus.tx_valid = 1'b0;
    bus.tx_data  = 8'h00;
    repeat (3) tick();
    check("rst_line", bus.tx_line, 1);
    check("rst_ready", bus.tx_ready, 1);
    check("rst_busy", bus.tx_busy, 0);
    check("rst_oe", bus.tx_oe, 1);
    rst = 1'b0;
    tick();
    check("idle_line", bus.tx_line, 1);
    check("idle_oe", bus.tx_oe, 1);

    // Single byte, checks exact frame length through ready timing.
    send(8'hA5, 1'b0);
    check_frame(-1);
    tick();
    check("a5_idle_line", bus.tx_line, 1);

    // Back-to-back with tx_valid held.
    send(8'h00, 1'b1);
    first_hs    = hs_cyc;
    bus.tx_data = 8'hFF;
    exp_q.push_back(8'hFF);
    check_frame(-1);
    check("b2b_gap_line", bus.tx_line, 1);
    tick();
    bus.tx_valid = 1'b0;
    check("b2b_period", cyc - first_hs, FRAME_BITS * N + 1);
    check_frame(-1);

    // tx_valid pulsed mid-frame must be ignored.
    send(8'h81, 1'b0);
    check_frame(3 * N + 1);
    repeat (2 * N) tick();
    check("ignore_line", bus.tx_line, 1);
    check("ignore_busy", bus.tx_busy, 0);

    // Reset in the middle of a frame.
    send(8'hF0, 1'b0);
    repeat (16) tick();
    rst = 1'b1;
    tick();
    check("midrst_line", bus.tx_line, 1);
    check("midrst_ready", bus.tx_ready, 1);
    check("midrst_busy", bus.tx_busy, 0);
    rst = 1'b0;
    void'(exp_q.pop_front());
    repeat (N) tick();
    check("postrst_line", bus.tx_line, 1);
    send(8'h55, 1'b0);
    check_frame(-1);

`ifdef WENNEB_UART_PARITY_EN
    send(8'h07, 1'b0);
    check("par07_len", FRAME_BITS * N, 44);
    check_frame(-1);
    send(8'h03, 1'b0);
    check_frame(-1);
`endif

    check("sb_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
